// File: rtl/coin_vend_ctrl_if.sv
// Coin vending controller signal bundle.
// Groups the coin-detect inputs, purchase/refund requests and all registered
// controller outputs.
//   slave  : the controller (consumes coins/requests, drives credit/pulses)
//   master : the coin sensor / front panel side (drives coins/requests)
interface coin_vend_ctrl_if;
  logic       penny;
  logic       nickel;
  logic       dime;
  logic       quarter;
  logic       select;
  logic       cancel;
  logic [7:0] credit;
  logic       dispense;
  logic       ret_quarter;
  logic       ret_dime;
  logic       ret_nickel;
  logic       ret_penny;
  logic       reject;
  logic       busy;

  modport slave (
    input  penny, nickel, dime, quarter, select, cancel,
    output credit, dispense, ret_quarter, ret_dime, ret_nickel, ret_penny,
           reject, busy
  );

  modport master (
    output penny, nickel, dime, quarter, select, cancel,
    input  credit, dispense, ret_quarter, ret_dime, ret_nickel, ret_penny,
           reject, busy
  );
endinterface

// File: rtl/coin_vend_ctrl.sv
// Coin vending controller.
// Accumulates credit from one-cycle coin pulses, vends an item when the
// credit covers PRICE, and pays out change / refunds one coin per cycle
// using the largest denomination that fits.
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : coin_vend_ctrl_if.slave
//           in : penny, nickel, dime, quarter, select, cancel
//           out: credit[7:0], dispense, ret_quarter/dime/nickel/penny,
//                reject, busy
//
// state  | meaning
// IDLE   | accepting coins, select and cancel
// VEND   | one cycle, dispense high, PRICE already deducted
// CHANGE | paying out remaining credit, one coin per cycle
module coin_vend_ctrl #(
  parameter int unsigned PRICE = 65
) (
  input  logic              clk,
  input  logic              reset,
  coin_vend_ctrl_if.slave   bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] VEND   = 2'd1;
  localparam logic [1:0] CHANGE = 2'd2;

  localparam logic [7:0] PRICE_C = 8'(PRICE);

  logic [1:0] state, state_nxt;
  logic [7:0] credit, credit_nxt;
  logic       dispense, dispense_nxt;
  logic [3:0] ret, ret_nxt;          // {quarter, dime, nickel, penny}
  logic       reject, reject_nxt;

  logic [8:0] coin_sum;
  logic [8:0] credit_sum;
  logic       any_coin;

  assign coin_sum = (bus.quarter ? 9'd25 : 9'd0)
                  + (bus.dime    ? 9'd10 : 9'd0)
                  + (bus.nickel  ? 9'd5  : 9'd0)
                  + (bus.penny   ? 9'd1  : 9'd0);
  assign any_coin   = bus.quarter | bus.dime | bus.nickel | bus.penny;
  // Worst case 255 + 41 fits in 9 bits, so bit 8 flags overflow.
  assign credit_sum = {1'b0, credit} + coin_sum;

  always_comb begin
    state_nxt    = state;
    credit_nxt   = credit;
    dispense_nxt = 1'b0;
    ret_nxt      = 4'b0000;
    reject_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cancel && credit != 8'd0) begin
          // Refund pays out exactly the credit seen here, so same-cycle coins
          // cannot be added.
          state_nxt  = CHANGE;
          reject_nxt = any_coin;
        end else if (bus.select && credit >= PRICE_C) begin
          state_nxt    = VEND;
          credit_nxt   = credit - PRICE_C;
          dispense_nxt = 1'b1;
          reject_nxt   = any_coin;
        end else if (any_coin) begin
          if (credit_sum[8]) begin
            reject_nxt = 1'b1;
          end else begin
            credit_nxt = credit_sum[7:0];
          end
        end
      end
      VEND: begin
        reject_nxt = any_coin;
        state_nxt  = (credit != 8'd0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        reject_nxt = any_coin;
        if (credit >= 8'd25) begin
          ret_nxt    = 4'b1000;
          credit_nxt = credit - 8'd25;
        end else if (credit >= 8'd10) begin
          ret_nxt    = 4'b0100;
          credit_nxt = credit - 8'd10;
        end else if (credit >= 8'd5) begin
          ret_nxt    = 4'b0010;
          credit_nxt = credit - 8'd5;
        end else if (credit != 8'd0) begin
          ret_nxt    = 4'b0001;
          credit_nxt = credit - 8'd1;
        end
        if (credit_nxt == 8'd0) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      credit   <= 8'd0;
      dispense <= 1'b0;
      ret      <= 4'b0000;
      reject   <= 1'b0;
    end else begin
      state    <= state_nxt;
      credit   <= credit_nxt;
      dispense <= dispense_nxt;
      ret      <= ret_nxt;
      reject   <= reject_nxt;
    end
  end

  assign bus.credit      = credit;
  assign bus.dispense    = dispense;
  assign bus.ret_quarter = ret[3];
  assign bus.ret_dime    = ret[2];
  assign bus.ret_nickel  = ret[1];
  assign bus.ret_penny   = ret[0];
  assign bus.reject      = reject;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_coin_vend_ctrl.sv
module tb_coin_vend_ctrl;
  localparam int PRICE = 65;

  logic clk;
  logic reset;
  coin_vend_ctrl_if bus ();

  coin_vend_ctrl #(.PRICE(PRICE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One expected post-edge observation.
  typedef struct {
    bit busy;
    bit disp;
    int ret;      // {quarter, dime, nickel, penny} one-hot or 0
    int credit;
  } exp_t;

  exp_t script[$];   // pending observations of an ongoing vend/refund
  int   m_credit;
  int   n_checks;
  int   n_pass;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int dut_ret();
    return {28'd0, bus.ret_quarter, bus.ret_dime, bus.ret_nickel, bus.ret_penny};
  endfunction

  // Queue one observation per change coin, greedy largest-first.
  function automatic void push_change(input int amount);
    int rem;
    int d;
    int code;
    exp_t e;
    rem = amount;
    while (rem > 0) begin
      if (rem >= 25)      begin d = 25; code = 8; end
      else if (rem >= 10) begin d = 10; code = 4; end
      else if (rem >= 5)  begin d = 5;  code = 2; end
      else                begin d = 1;  code = 1; end
      rem -= d;
      e = '{busy: (rem > 0), disp: 1'b0, ret: code, credit: rem};
      script.push_back(e);
    end
  endfunction

  task automatic compare_all(input exp_t e, input bit rej);
    check("credit",   int'(bus.credit),   e.credit);
    check("busy",     int'(bus.busy),     int'(e.busy));
    check("dispense", int'(bus.dispense), int'(e.disp));
    check("ret",      dut_ret(),          e.ret);
    check("reject",   int'(bus.reject),   int'(rej));
  endtask

  // coins = {quarter, dime, nickel, penny}
  task automatic step(input logic [3:0] coins, input bit sel, input bit can);
    int   sum;
    bit   any;
    bit   rej;
    exp_t e;
    exp_t tail;
    bus.quarter = coins[3];
    bus.dime    = coins[2];
    bus.nickel  = coins[1];
    bus.penny   = coins[0];
    bus.select  = sel;
    bus.cancel  = can;
    @(posedge clk);
    sum = 25 * int'(coins[3]) + 10 * int'(coins[2]) + 5 * int'(coins[1]) + int'(coins[0]);
    any = (coins != 4'b0000);
    if (script.size() > 0) begin
      e   = script.pop_front();
      rej = any;
    end else begin
      rej = 1'b0;
      e   = '{busy: 1'b0, disp: 1'b0, ret: 0, credit: m_credit};
      if (can && m_credit > 0) begin
        e   = '{busy: 1'b1, disp: 1'b0, ret: 0, credit: m_credit};
        push_change(m_credit);
        rej = any;
      end else if (sel && m_credit >= PRICE) begin
        e = '{busy: 1'b1, disp: 1'b1, ret: 0, credit: m_credit - PRICE};
        if (e.credit > 0) begin
          tail = '{busy: 1'b1, disp: 1'b0, ret: 0, credit: e.credit};
          script.push_back(tail);
          push_change(e.credit);
        end else begin
          tail = '{busy: 1'b0, disp: 1'b0, ret: 0, credit: 0};
          script.push_back(tail);
        end
        rej = any;
      end else if (any) begin
        if (m_credit + sum > 255) rej = 1'b1;
        else e.credit = m_credit + sum;
      end
    end
    m_credit = e.credit;
    #1;
    compare_all(e, rej);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulse placed mid-cycle, checked before any clock edge.
  task automatic mid_cycle_reset();
    exp_t z;
    #2;
    reset = 1'b0;
    #1;
    z = '{busy: 1'b0, disp: 1'b0, ret: 0, credit: 0};
    compare_all(z, 1'b0);
    script.delete();
    m_credit = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    exp_t z;
    logic [3:0] rc;
    n_checks = 0;
    n_pass   = 0;
    m_credit = 0;
    reset = 1'b0;
    bus.quarter = 1'b0; bus.dime = 1'b0; bus.nickel = 1'b0; bus.penny = 1'b0;
    bus.select = 1'b0;  bus.cancel = 1'b0;
    #1;
    z = '{busy: 1'b0, disp: 1'b0, ret: 0, credit: 0};
    compare_all(z, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Three quarters on separate cycles, then buy: change is one dime.
    step(4'b1000, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b1000, 0, 0);
    step(4'b1000, 0, 0);
    check("credit_75", int'(bus.credit), 75);
    step(4'b0000, 1, 0);
    check("vend_dispense", int'(bus.dispense), 1);
    check("vend_credit", int'(bus.credit), 10);
    idle(3);

    // All four coins in one cycle, then cancel.
    step(4'b1111, 0, 0);
    check("combo_credit", int'(bus.credit), 41);
    check("combo_reject", int'(bus.reject), 0);
    step(4'b0000, 0, 1);
    idle(5);

    // Upper bound: 250 + 5 = 255 accepted, +1 rejected.
    for (int i = 0; i < 10; i++) step(4'b1000, 0, 0);
    step(4'b0010, 0, 0);
    check("credit_255", int'(bus.credit), 255);
    step(4'b0001, 0, 0);
    check("overflow_reject", int'(bus.reject), 1);
    check("overflow_credit", int'(bus.credit), 255);
    step(4'b0000, 0, 1);
    idle(13);

    // Select below price ignored; select+cancel refunds.
    step(4'b1100, 0, 0);
    step(4'b1000, 0, 0);
    step(4'b0000, 1, 0);
    check("low_select_busy", int'(bus.busy), 0);
    step(4'b0010, 0, 0);
    step(4'b0100, 0, 0);
    step(4'b0000, 1, 1);
    check("sel_cancel_nodisp", int'(bus.dispense), 0);
    idle(5);

    // Coins during a vend are rejected.
    step(4'b1000, 0, 0);
    step(4'b1000, 0, 0);
    step(4'b1000, 0, 0);
    step(4'b0001, 1, 0);
    step(4'b0100, 0, 1);
    step(4'b1000, 0, 0);
    idle(3);

    // Reset during CHANGE with 30 remaining, then restart.
    step(4'b1010, 0, 0);
    step(4'b0000, 0, 1);
    check("change_credit_30", int'(bus.credit), 30);
    mid_cycle_reset();
    step(4'b1000, 0, 0);
    check("post_reset_credit", int'(bus.credit), 25);
    idle(3);
    check("no_resume_busy", int'(bus.busy), 0);

    // Reset during VEND while dispense is high.
    step(4'b1000, 0, 0);
    step(4'b1000, 0, 0);
    step(4'b0000, 1, 0);
    mid_cycle_reset();
    idle(2);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      rc[3] = ($urandom_range(0, 5) == 0);
      rc[2] = ($urandom_range(0, 5) == 0);
      rc[1] = ($urandom_range(0, 5) == 0);
      rc[0] = ($urandom_range(0, 5) == 0);
      step(rc, ($urandom_range(0, 4) == 0), ($urandom_range(0, 11) == 0));
    end
    idle(15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
